// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer for the basic_proc fetch stage: start/hold handshake,
// absolute/relative branches, halt/done and an optional call/return stack (PROG_CTR_STACK_EN).
module prog_ctr_seq #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    input  logic               BranchAbs,
    input  logic               BranchRel,
    input  logic               ALU_flag,
    input  logic [PC_W-1:0]    Target,
    input  logic [OFF_W-1:0]   Offset,
    input  logic               Call,
    input  logic               Ret,
    input  logic               Halt,
    output logic [PC_W-1:0]    ProgCtr,
    output logic               Running,
    output logic               Done,
    output logic               StackErr,
    output logic [DEPTH_W-1:0] Depth
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               running_q, done_q, stack_err_q;
    logic [PC_W-1:0]    pc_inc_s;
    logic [PC_W-1:0]    pc_rel_s;

    // Both sums wrap naturally modulo 2^PC_W; the offset is sign-extended by the cast.
    assign pc_inc_s = pc_q + PC_W'(1);
    assign pc_rel_s = pc_q + PC_W'($signed(Offset));

`ifdef PROG_CTR_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic             push_en_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    assign push_idx_s = IDX_W'(depth_q);
    assign top_idx_s  = IDX_W'(depth_q - DEPTH_W'(1));

    // Return-address storage; contents need no reset since Depth gates every read.
    always_ff @(posedge Clk) begin
        if (push_en_s) begin
            stack_q[push_idx_s] <= pc_inc_s;
        end
    end
`endif

    // Next-state, next-PC and stack-occupancy decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
`ifdef PROG_CTR_STACK_EN
        push_en_s = 1'b0;
`endif
        if (Start) begin
            state_d = ST_HOLD;
            pc_d    = StartAddr;
            depth_d = DEPTH_W'(0);
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_HOLD:  state_d = ST_RUN;
                ST_RUN: begin
                    if (Halt) begin
                        state_d = ST_DONE;
                    end else if (Ret) begin
`ifdef PROG_CTR_STACK_EN
                        if (depth_q == DEPTH_W'(0)) begin
                            state_d = ST_FAULT;
                        end else begin
                            pc_d    = stack_q[top_idx_s];
                            depth_d = depth_q - DEPTH_W'(1);
                        end
`else
                        pc_d = pc_inc_s;
`endif
                    end else if (Call) begin
`ifdef PROG_CTR_STACK_EN
                        if (depth_q == DEPTH_FULL) begin
                            state_d = ST_FAULT;
                        end else begin
                            push_en_s = 1'b1;
                            pc_d      = Target;
                            depth_d   = depth_q + DEPTH_W'(1);
                        end
`else
                        pc_d = Target;
`endif
                    end else if (BranchAbs) begin
                        pc_d = Target;
                    end else if (BranchRel && ALU_flag) begin
                        pc_d = pc_rel_s;
                    end else begin
                        pc_d = pc_inc_s;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State, PC and registered status outputs decoded from the next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_W'(0);
            depth_q     <= DEPTH_W'(0);
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            running_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            stack_err_q <= (state_d == ST_FAULT);
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign StackErr = stack_err_q;
    assign Depth    = depth_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed self-checking bench for prog_ctr_seq; stack scenarios run when PROG_CTR_STACK_EN is defined.
module tb_prog_ctr_seq;

    logic       Clk = 1'b0;
    logic       Reset_n, Start, BranchAbs, BranchRel, ALU_flag, Call, Ret, Halt;
    logic [9:0] StartAddr, Target, ProgCtr;
    logic [7:0] Offset;
    logic       Running, Done, StackErr;
    logic [2:0] Depth;

    int total = 0;
    int bad   = 0;

    prog_ctr_seq dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .ALU_flag(ALU_flag),
        .Target(Target), .Offset(Offset), .Call(Call), .Ret(Ret), .Halt(Halt),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .StackErr(StackErr),
        .Depth(Depth)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_strobes();
        Start = 1'b0; BranchAbs = 1'b0; BranchRel = 1'b0; ALU_flag = 1'b0;
        Call = 1'b0; Ret = 1'b0; Halt = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] addr);
        clear_strobes();
        Start = 1'b1; StartAddr = addr;
        tick();
        Start = 1'b0;
        tick();
    endtask

    task automatic jump(input logic [9:0] addr);
        clear_strobes();
        BranchAbs = 1'b1; Target = addr;
        tick();
        clear_strobes();
    endtask

    initial begin
        clear_strobes();
        Reset_n = 1'b0; StartAddr = 10'h000; Target = 10'h000; Offset = 8'h00;
        tick();
        check_val("rst_pc",   32'(ProgCtr),  32'h0);
        check_val("rst_run",  32'(Running),  32'h0);
        check_val("rst_done", 32'(Done),     32'h0);
        check_val("rst_err",  32'(StackErr), 32'h0);
        check_val("rst_dep",  32'(Depth),    32'h0);
        Reset_n = 1'b1;
        tick();

        // Run to 0x1F3 then assert reset mid-cycle.
        do_start(10'h1F0);
        check_val("run_first", 32'(ProgCtr), 32'h1F0);
        tick(); tick(); tick();
        check_val("run_1f3", 32'(ProgCtr), 32'h1F3);
        Reset_n = 1'b0;
        #1;
        check_val("async_pc",  32'(ProgCtr), 32'h0);
        check_val("async_run", 32'(Running), 32'h0);
        #1;
        Reset_n = 1'b1;
        tick();
        check_val("idle_pc", 32'(ProgCtr), 32'h0);

        // Start held for three cycles.
        Start = 1'b1; StartAddr = 10'h040;
        tick(); tick(); tick();
        check_val("hold_pc",  32'(ProgCtr), 32'h040);
        check_val("hold_run", 32'(Running), 32'h0);
        Start = 1'b0;
        tick();
        check_val("run_pc0",  32'(ProgCtr), 32'h040);
        check_val("run_run",  32'(Running), 32'h1);
        tick();
        check_val("run_pc1",  32'(ProgCtr), 32'h041);
        tick();
        check_val("run_pc2",  32'(ProgCtr), 32'h042);

        // Relative branches and wrap.
        jump(10'h050);
        check_val("abs_050", 32'(ProgCtr), 32'h050);
        BranchRel = 1'b1; ALU_flag = 1'b1; Offset = 8'hFD;
        tick();
        check_val("rel_taken", 32'(ProgCtr), 32'h04D);
        jump(10'h050);
        BranchRel = 1'b1; ALU_flag = 1'b0; Offset = 8'hFD;
        tick();
        check_val("rel_nottaken", 32'(ProgCtr), 32'h051);
        jump(10'h3FF);
        check_val("abs_3ff", 32'(ProgCtr), 32'h3FF);
        tick();
        check_val("inc_wrap", 32'(ProgCtr), 32'h000);
        BranchRel = 1'b1; ALU_flag = 1'b1; Offset = 8'hFD;
        tick();
        check_val("rel_wrap", 32'(ProgCtr), 32'h3FD);
        clear_strobes();
        BranchRel = 1'b1; ALU_flag = 1'b1; Offset = 8'h05;
        tick();
        check_val("rel_pos", 32'(ProgCtr), 32'h002);
        clear_strobes();

`ifndef PROG_CTR_STACK_EN
        // Without the stack, Call is a jump and Ret an increment.
        Call = 1'b1; Target = 10'h123;
        tick();
        check_val("nostk_call", 32'(ProgCtr), 32'h123);
        check_val("nostk_dep",  32'(Depth),   32'h0);
        clear_strobes();
        Ret = 1'b1;
        tick();
        check_val("nostk_ret", 32'(ProgCtr), 32'h124);
        tick();
        check_val("nostk_ret2", 32'(ProgCtr), 32'h125);
        check_val("nostk_err",  32'(StackErr), 32'h0);
        clear_strobes();
`endif

        // Halt beats Call and BranchAbs.
        jump(10'h010);
        Halt = 1'b1; Call = 1'b1; BranchAbs = 1'b1; Target = 10'h200;
        tick();
        check_val("halt_pc",   32'(ProgCtr), 32'h010);
        check_val("halt_done", 32'(Done),    32'h1);
        check_val("halt_run",  32'(Running), 32'h0);
        check_val("halt_dep",  32'(Depth),   32'h0);
        clear_strobes();
        BranchAbs = 1'b1; Target = 10'h2AA;
        tick(); tick();
        check_val("done_pc",  32'(ProgCtr), 32'h010);
        check_val("done_hi",  32'(Done),    32'h1);
        clear_strobes();
        Start = 1'b1; StartAddr = 10'h300;
        tick();
        check_val("restart_pc",   32'(ProgCtr), 32'h300);
        check_val("restart_done", 32'(Done),    32'h0);
        Start = 1'b0;
        tick();
        check_val("restart_run", 32'(Running), 32'h1);

`ifdef PROG_CTR_STACK_EN
        // Fill the stack, then overflow.
        do_start(10'h100);
        Call = 1'b1; Target = 10'h200; tick();
        Target = 10'h300; tick();
        Target = 10'h380; tick();
        Target = 10'h3C0; tick();
        check_val("fill_dep", 32'(Depth),   32'h4);
        check_val("fill_pc",  32'(ProgCtr), 32'h3C0);
        Target = 10'h0AA; tick();
        check_val("ovf_err", 32'(StackErr), 32'h1);
        check_val("ovf_pc",  32'(ProgCtr),  32'h3C0);
        check_val("ovf_run", 32'(Running),  32'h0);
        clear_strobes();
        Ret = 1'b1; tick();
        check_val("ovf_sticky", 32'(StackErr), 32'h1);
        clear_strobes();
        Start = 1'b1; StartAddr = 10'h100; tick();
        check_val("rst_fault_err", 32'(StackErr), 32'h0);
        check_val("rst_fault_dep", 32'(Depth),    32'h0);
        check_val("rst_fault_pc",  32'(ProgCtr),  32'h100);
        Start = 1'b0; tick();
        // Nested call/return.
        Call = 1'b1; Target = 10'h200; tick();
        Target = 10'h300; tick();
        check_val("nest_dep", 32'(Depth), 32'h2);
        clear_strobes();
        Ret = 1'b1; tick();
        check_val("ret_201", 32'(ProgCtr), 32'h201);
        tick();
        check_val("ret_101", 32'(ProgCtr), 32'h101);
        check_val("ret_dep", 32'(Depth),   32'h0);
        tick();
        check_val("unf_err", 32'(StackErr), 32'h1);
        check_val("unf_pc",  32'(ProgCtr),  32'h101);
        clear_strobes();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
